// File: rtl/soc_pad_bridge.sv
// Pad-side bridge: gathers narrow pad beats into core requests, serialises read returns
// back onto the pad, and runs the execution-start handshake.
`timescale 1ns/1ps

module soc_pad_bridge_rsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic rstn_sync
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign rstn_sync = sync_q[STAGES-1];
endmodule

module soc_pad_bridge #(
  parameter int PAD_W       = 16,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int RD_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              chip_en,
  input  logic [PAD_W-1:0]  pad_din,
  input  logic [1:0]        pad_valid,
  input  logic              pad_rw,
  output logic [PAD_W-1:0]  pad_dout,
  output logic              pad_dout_valid,
  input  logic              scan_start_exec,
  output logic              exec_end,
  output logic              proto_err,
  output logic              core_req,
  output logic              core_we,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_wdata,
  input  logic              core_gnt,
  input  logic              core_rvalid,
  input  logic [DATA_W-1:0] core_rdata,
  output logic              core_start,
  input  logic              core_done,
  output logic              rstn_sync
);
  localparam int AB  = (ADDR_W + PAD_W - 1) / PAD_W;
  localparam int DB  = DATA_W / PAD_W;
  localparam int ACW = (AB > 1) ? $clog2(AB) : 1;
  localparam int DCW = (DB > 1) ? $clog2(DB) : 1;
  localparam int PW  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam logic [ACW-1:0] A_LAST = ACW'(AB - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DB - 1);
  localparam logic [PW:0]    F_FULL = (PW+1)'(RD_DEPTH);

  typedef enum logic [2:0] {IDLE, ACOL, DCOL, ISSUE, RWAIT} state_t;

  logic rst_n_i;

  soc_pad_bridge_rsync #(.STAGES(SYNC_STAGES)) u_rsync (
    .clk       (clk),
    .rstn      (rstn),
    .rstn_sync (rst_n_i)
  );
  assign rstn_sync = rst_n_i;

  state_t                       state_q, state_d;
  logic                         rw_q, rw_d;
  logic [ACW-1:0]               acnt_q, acnt_d;
  logic [DCW-1:0]               dcnt_q, dcnt_d;
  logic [AB-1:0][PAD_W-1:0]     abuf_q, abuf_d;
  logic [DB-1:0][PAD_W-1:0]     dbuf_q, dbuf_d;
  logic                         perr_q, perr_d;
  logic [RD_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]                  cnt_q, cnt_d;
  logic [DATA_W-1:0]            ser_q, ser_d;
  logic                         sact_q, sact_d;
  logic [DCW-1:0]               scnt_q, scnt_d;
  logic                         scan_q, scan_d, busy_q, busy_d;
  logic                         start_q, start_d, eend_q, eend_d;

  logic abeat, dbeat, push, pop, fifo_full, fifo_empty, accept;

  assign abeat      = chip_en && (pad_valid == 2'b01);
  assign dbeat      = chip_en && (pad_valid == 2'b10);
  assign fifo_full  = (cnt_q == F_FULL);
  assign fifo_empty = (cnt_q == '0);

  // Reads hold off while the return FIFO has no room; writes never touch it.
  assign core_req   = (state_q == ISSUE) && (rw_q || !fifo_full);
  assign core_we    = rw_q;
  assign core_addr  = ADDR_W'(abuf_q);
  assign core_wdata = dbuf_q;
  assign proto_err  = perr_q;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    abuf_d  = abuf_q;
    dbuf_d  = dbuf_q;
    perr_d  = perr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (abeat) begin
          abuf_d[0] = pad_din;
          rw_d      = pad_rw;
          dcnt_d    = '0;
          if (AB == 1) begin
            state_d = pad_rw ? DCOL : ISSUE;
          end else begin
            acnt_d  = ACW'(1);
            state_d = ACOL;
          end
        end else if (dbeat) begin
          perr_d = 1'b1;
        end
      end
      ACOL: begin
        if (abeat) begin
          abuf_d[acnt_q] = pad_din;
          if (acnt_q == A_LAST) begin
            acnt_d  = '0;
            state_d = rw_q ? DCOL : ISSUE;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end else if (dbeat) begin
          perr_d = 1'b1;
        end
      end
      DCOL: begin
        if (dbeat) begin
          dbuf_d[dcnt_q] = pad_din;
          if (dcnt_q == D_LAST) begin
            dcnt_d  = '0;
            state_d = ISSUE;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end else if (abeat) begin
          perr_d = 1'b1;
        end
      end
      ISSUE: begin
        if (abeat || dbeat) perr_d = 1'b1;
        if (core_req && core_gnt) state_d = rw_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        if (abeat || dbeat) perr_d = 1'b1;
        if (core_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return FIFO and pad serialiser; a new word is taken only when the serialiser is idle.
  assign pop = !sact_q && !fifo_empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ser_d  = ser_q;
    sact_d = sact_q;
    scnt_d = scnt_q;
    if (push) begin
      mem_d[wptr_q] = core_rdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      ser_d  = mem_q[rptr_q];
      sact_d = 1'b1;
      scnt_d = '0;
    end else if (sact_q) begin
      ser_d = ser_q >> PAD_W;
      if (scnt_q == D_LAST) begin
        sact_d = 1'b0;
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  assign pad_dout       = sact_q ? ser_q[PAD_W-1:0] : '0;
  assign pad_dout_valid = sact_q;

  // Execution handshake: only the first rising edge of a busy period is honoured.
  assign accept = scan_start_exec && !scan_q && !busy_q;

  always_comb begin
    scan_d  = scan_start_exec;
    start_d = accept;
    busy_d  = busy_q;
    eend_d  = eend_q;
    if (accept) begin
      busy_d = 1'b1;
      eend_d = 1'b0;
    end else if (busy_q && core_done) begin
      busy_d = 1'b0;
      eend_d = 1'b1;
    end
  end

  assign core_start = start_q;
  assign exec_end   = eend_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      abuf_q  <= '0;
      dbuf_q  <= '0;
      perr_q  <= 1'b0;
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= '0;
      sact_q  <= 1'b0;
      scnt_q  <= '0;
      scan_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      eend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      abuf_q  <= abuf_d;
      dbuf_q  <= dbuf_d;
      perr_q  <= perr_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      sact_q  <= sact_d;
      scnt_q  <= scnt_d;
      scan_q  <= scan_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      eend_q  <= eend_d;
    end
  end
endmodule
